// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory arbiter and its response registers.
package imem_pkg;

    localparam int          IMEM_DEPTH = 64;
    localparam int          IMEM_IDX_W = $clog2(IMEM_DEPTH);
    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

    typedef enum logic {
        OWN_FETCH,
        OWN_LOADER
    } owner_t;

    typedef enum logic {
        ARB,
        LOCK
    } arb_state_t;

endpackage

// File: rtl/imem_rsp_reg.sv
// Per-port response register: captures read data (or write ack / error substitute) at the grant edge.
// OOR_RDATA is returned in place of memory data when the granted request was out of range.
module imem_rsp_reg #(
    parameter logic [31:0] OOR_RDATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        gnt_i,
    input  logic        we_i,
    input  logic        oor_i,
    input  logic [31:0] mem_rdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    always_comb begin
        rvalid_d = gnt_i;
        err_d    = gnt_i & oor_i;
        rdata_d  = '0;
        if (gnt_i) begin
            if (oor_i) begin
                rdata_d = OOR_RDATA;
            end else if (!we_i) begin
                rdata_d = mem_rdata_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction-memory arbiter between core fetch (read-only) and the program loader.
// Out-of-range address detection is compiled in only when IMEM_ARB_RANGE_CHECK_EN is defined.
//
// state | meaning
// ARB   | round-robin between fetch and loader, alternating away from last_owner
// LOCK  | loader has priority; fetch gets one slot after LOAD_MAX_BURST loader grants
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int DEPTH          = IMEM_DEPTH,
    parameter int IDX_W          = (DEPTH == IMEM_DEPTH) ? IMEM_IDX_W : $clog2(DEPTH),
    parameter int LOAD_MAX_BURST = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             f_req,
    input  logic [31:0]      f_addr,
    output logic             f_gnt,
    output logic             f_rvalid,
    output logic [31:0]      f_rdata,
    input  logic             l_req,
    input  logic             l_we,
    input  logic             l_lock,
    input  logic [31:0]      l_addr,
    input  logic [31:0]      l_wdata,
    output logic             l_gnt,
    output logic             l_rvalid,
    output logic [31:0]      l_rdata,
    output logic [IDX_W-1:0] m_idx,
    output logic             m_we,
    output logic [31:0]      m_wdata,
    input  logic [31:0]      m_rdata,
    output logic             err
);

    localparam int               CNT_W     = $clog2(LOAD_MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(LOAD_MAX_BURST);

    arb_state_t       state_q, state_d;
    owner_t           last_owner_q, last_owner_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [IDX_W-1:0] m_idx_q;
    logic [IDX_W-1:0] f_idx, l_idx;
    logic             gnt_f, gnt_l;
    logic             f_oor, l_oor;
    logic             f_err, l_err;

    assign f_idx = f_addr[IDX_W+1:2];
    assign l_idx = l_addr[IDX_W+1:2];

`ifdef IMEM_ARB_RANGE_CHECK_EN
    assign f_oor = |f_addr[31:IDX_W+2];
    assign l_oor = |l_addr[31:IDX_W+2];
`else
    assign f_oor = 1'b0;
    assign l_oor = 1'b0;
`endif

    logic unused_addr_bits;
    assign unused_addr_bits = ^{f_addr[1:0], l_addr[1:0], f_addr[31:IDX_W+2], l_addr[31:IDX_W+2]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB;
            last_owner_q <= OWN_LOADER;
            burst_cnt_q  <= '0;
            m_idx_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            m_idx_q      <= m_idx;
        end
    end

    // A lock only survives while the loader keeps both l_req and l_lock up;
    // otherwise this cycle is arbitrated exactly as in ARB.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        gnt_f        = 1'b0;
        gnt_l        = 1'b0;
        if (!reset) begin
            if (state_q == LOCK && l_req && l_lock) begin
                if (f_req && burst_cnt_q == BURST_MAX) begin
                    gnt_f       = 1'b1;
                    burst_cnt_d = '0;
                end else begin
                    gnt_l = 1'b1;
                    if (f_req && burst_cnt_q != BURST_MAX) begin
                        burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    end
                end
            end else begin
                state_d = ARB;
                if (f_req && l_req) begin
                    gnt_f = (last_owner_q == OWN_LOADER);
                    gnt_l = (last_owner_q == OWN_FETCH);
                end else begin
                    gnt_f = f_req;
                    gnt_l = l_req;
                end
                if (gnt_l && l_lock) begin
                    state_d     = LOCK;
                    burst_cnt_d = '0;
                end
            end
            if (gnt_f) begin
                last_owner_d = OWN_FETCH;
            end else if (gnt_l) begin
                last_owner_d = OWN_LOADER;
            end
        end
    end

    always_comb begin
        f_gnt   = gnt_f;
        l_gnt   = gnt_l;
        m_idx   = m_idx_q;
        m_we    = 1'b0;
        m_wdata = '0;
        if (reset) begin
            m_idx = '0;
        end else if (gnt_f) begin
            m_idx = f_idx;
        end else if (gnt_l) begin
            m_idx   = l_idx;
            m_we    = l_we & ~l_oor;
            m_wdata = l_wdata;
        end
    end

    imem_rsp_reg #(
        .OOR_RDATA (NOP_INSN)
    ) u_fetch_rsp (
        .clk         (clk),
        .reset       (reset),
        .gnt_i       (gnt_f),
        .we_i        (1'b0),
        .oor_i       (f_oor),
        .mem_rdata_i (m_rdata),
        .rvalid_o    (f_rvalid),
        .rdata_o     (f_rdata),
        .err_o       (f_err)
    );

    imem_rsp_reg #(
        .OOR_RDATA (32'h0000_0000)
    ) u_loader_rsp (
        .clk         (clk),
        .reset       (reset),
        .gnt_i       (gnt_l),
        .we_i        (l_we),
        .oor_i       (l_oor),
        .mem_rdata_i (m_rdata),
        .rvalid_o    (l_rvalid),
        .rdata_o     (l_rdata),
        .err_o       (l_err)
    );

`ifdef IMEM_ARB_RANGE_CHECK_EN
    assign err = f_err | l_err;
`else
    logic unused_err;
    assign unused_err = f_err ^ l_err;
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed literal scenarios plus randomized traffic against a behavioural model.
// Honours IMEM_ARB_RANGE_CHECK_EN the same way the design does.
module tb_imem_arbiter;

    localparam int TB_DEPTH = 64;
    localparam int MAXB     = 8;

    logic        clk;
    logic        reset;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        l_req;
    logic        l_we;
    logic        l_lock;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic        l_gnt;
    logic        l_rvalid;
    logic [31:0] l_rdata;
    logic [5:0]  m_idx;
    logic        m_we;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] env_mem [TB_DEPTH];
    logic [31:0] ref_mem [TB_DEPTH];

    imem_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_gnt    (f_gnt),
        .f_rvalid (f_rvalid),
        .f_rdata  (f_rdata),
        .l_req    (l_req),
        .l_we     (l_we),
        .l_lock   (l_lock),
        .l_addr   (l_addr),
        .l_wdata  (l_wdata),
        .l_gnt    (l_gnt),
        .l_rvalid (l_rvalid),
        .l_rdata  (l_rdata),
        .m_idx    (m_idx),
        .m_we     (m_we),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // external single-port memory, combinational read
    assign m_rdata = env_mem[m_idx];
    always @(posedge clk) begin
        if (m_we) env_mem[m_idx] <= m_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'(a % 32'd256) / 4;
    endfunction

    function automatic bit out_of_range(input logic [31:0] a);
`ifdef IMEM_ARB_RANGE_CHECK_EN
        return a > 32'd255;
`else
        return (a != a);
`endif
    endfunction

    // ---------------- behavioural model ----------------
    bit          locked;
    bit          prefer_fetch;
    int          streak;
    int          last_idx;
    bit          pf_valid, pf_err, pl_valid, pl_err;
    logic [31:0] pf_data, pl_data;
    bit          mg_f, mg_l, mw;
    int          fi, li, ei;

    always @(negedge clk) begin
        if (reset) begin
            check("rst_f_gnt", f_gnt, 0);
            check("rst_l_gnt", l_gnt, 0);
            check("rst_m_we", m_we, 0);
            locked       = 0;
            prefer_fetch = 1;
            streak       = 0;
            last_idx     = 0;
            pf_valid     = 0;
            pl_valid     = 0;
            pf_err       = 0;
            pl_err       = 0;
        end else begin
            fi   = word_of(f_addr);
            li   = word_of(l_addr);
            mg_f = 0;
            mg_l = 0;
            if (locked && l_req && l_lock) begin
                if (f_req && streak == MAXB) mg_f = 1;
                else                         mg_l = 1;
            end else begin
                locked = 0;
                if (f_req && l_req) begin
                    mg_f = prefer_fetch;
                    mg_l = !prefer_fetch;
                end else begin
                    mg_f = f_req;
                    mg_l = l_req;
                end
            end
            check("m_f_gnt", f_gnt, mg_f);
            check("m_l_gnt", l_gnt, mg_l);
            ei = mg_f ? fi : (mg_l ? li : last_idx);
            check("m_idx", m_idx, ei);
            mw = mg_l && l_we && !out_of_range(l_addr);
            check("m_we", m_we, mw);
            if (mw) check("m_wdata", m_wdata, l_wdata);

            check("m_f_rvalid", f_rvalid, pf_valid);
            if (pf_valid) check("m_f_rdata", f_rdata, pf_data);
            check("m_l_rvalid", l_rvalid, pl_valid);
            if (pl_valid) check("m_l_rdata", l_rdata, pl_data);
            check("m_err", err, (pf_valid && pf_err) || (pl_valid && pl_err));

            pf_valid = mg_f;
            pf_err   = mg_f && out_of_range(f_addr);
            pf_data  = pf_err ? 32'h0000_0013 : ref_mem[fi];
            pl_valid = mg_l;
            pl_err   = mg_l && out_of_range(l_addr);
            pl_data  = (pl_err || l_we) ? 32'h0 : ref_mem[li];
            if (mw) ref_mem[li] = l_wdata;
            last_idx = ei;

            if (mg_f) begin
                prefer_fetch = 0;
                streak       = 0;
            end
            if (mg_l) begin
                prefer_fetch = 1;
                if (!locked && l_lock) begin
                    locked = 1;
                    streak = 0;
                end else if (locked && f_req && streak < MAXB) begin
                    streak++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 15) == 0) return $urandom();
        return 32'($urandom_range(0, 255));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    bit fg, lg;
    bit exp_f;

    initial begin
        for (int i = 0; i < TB_DEPTH; i++) begin
            env_mem[i] = 32'hA500_0000 | 32'(i);
            ref_mem[i] = 32'hA500_0000 | 32'(i);
        end
        reset = 1; f_req = 0; f_addr = 0; l_req = 0; l_we = 0; l_lock = 0; l_addr = 0; l_wdata = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;

        // reset state
        to_neg();
        check("reset_f_gnt", f_gnt, 0);
        check("reset_l_gnt", l_gnt, 0);
        check("reset_f_rvalid", f_rvalid, 0);
        check("reset_l_rvalid", l_rvalid, 0);
        check("reset_m_we", m_we, 0);
        check("reset_m_idx", m_idx, 0);
        check("reset_err", err, 0);

        // fetch-only read of byte address 0x8
        to_pos(); f_req = 1; f_addr = 32'h8;
        to_neg();
        check("fetch_gnt", f_gnt, 1);
        check("fetch_m_idx", m_idx, 2);
        to_pos(); f_req = 0;
        to_neg();
        check("fetch_rvalid", f_rvalid, 1);
        check("fetch_rdata", f_rdata, 32'hA500_0002);

        // contention right after reset: fetch first, then alternate
        to_pos(); reset = 1;
        to_pos(); reset = 0;
        f_req = 1; f_addr = 32'hC; l_req = 1; l_we = 0; l_lock = 0; l_addr = 32'h4;
        for (int i = 0; i < 6; i++) begin
            to_neg();
            check("contend_f_gnt", f_gnt, (i % 2 == 0));
            check("contend_l_gnt", l_gnt, (i % 2 == 1));
            to_pos();
        end

        // loader write then fetch read of the same word
        f_req = 0; l_req = 1; l_we = 1; l_addr = 32'h10; l_wdata = 32'hDEAD_BEEF;
        to_neg();
        check("wr_l_gnt", l_gnt, 1);
        check("wr_m_we", m_we, 1);
        to_pos(); l_req = 0; l_we = 0; f_req = 1; f_addr = 32'h10;
        to_neg();
        check("wr_ack_rvalid", l_rvalid, 1);
        check("wr_ack_rdata", l_rdata, 0);
        check("raw_f_gnt", f_gnt, 1);
        to_pos(); f_req = 0;
        to_neg();
        check("raw_f_rdata", f_rdata, 32'hDEAD_BEEF);

        // locked burst: 1 ARB grant + 8 locked grants, then fetch every 9th cycle
        to_pos();
        f_req = 1; f_addr = 32'h20; l_req = 1; l_lock = 1; l_we = 0; l_addr = 32'h24;
        for (int i = 0; i < 40; i++) begin
            to_neg();
            exp_f = (i >= 9) && ((i - 9) % 9 == 0);
            check("lock_f_gnt", f_gnt, exp_f);
            check("lock_l_gnt", l_gnt, !exp_f);
            to_pos();
        end
        l_lock = 0;
        for (int j = 0; j < 6; j++) begin
            to_neg();
            check("unlock_f_gnt", f_gnt, (j % 2 == 0));
            to_pos();
        end

        // reset the cycle after a grant
        l_req = 0; f_req = 1; f_addr = 32'h4;
        to_neg();
        check("pre_rst_gnt", f_gnt, 1);
        to_pos(); reset = 1; f_req = 0;
        to_neg();
        check("in_rst_gnt", f_gnt, 0);
        to_pos(); reset = 0;
        to_neg();
        check("post_rst_f_rvalid", f_rvalid, 0);
        check("post_rst_l_rvalid", l_rvalid, 0);
        check("post_rst_m_idx", m_idx, 0);
        check("post_rst_err", err, 0);
        to_pos(); f_req = 1; f_addr = 32'h8; l_req = 1; l_we = 0; l_addr = 32'h28;
        to_neg();
        check("post_rst_contend", f_gnt, 1);
        to_pos(); f_req = 0;
        to_neg();
        check("post_rst_l_next", l_gnt, 1);
        to_pos(); l_req = 0;

        // address 0x100: out of range with the feature, wraps to word 0 without it
        f_req = 1; f_addr = 32'h100;
        to_neg();
        check("oor_f_gnt", f_gnt, 1);
        check("oor_f_m_we", m_we, 0);
        check("oor_f_idx", m_idx, 0);
        to_pos(); f_req = 0; l_req = 1; l_we = 1; l_addr = 32'h100; l_wdata = 32'h1234_5678;
        to_neg();
        check("oor_f_rvalid", f_rvalid, 1);
`ifdef IMEM_ARB_RANGE_CHECK_EN
        check("oor_f_err", err, 1);
        check("oor_f_rdata", f_rdata, 32'h0000_0013);
        check("oor_l_m_we", m_we, 0);
`else
        check("oor_f_err", err, 0);
        check("oor_f_rdata", f_rdata, 32'hA500_0000);
        check("oor_l_m_we", m_we, 1);
`endif
        to_pos(); l_req = 0; l_we = 0;
        to_neg();
        check("oor_l_rvalid", l_rvalid, 1);
        check("oor_l_rdata", l_rdata, 0);
`ifdef IMEM_ARB_RANGE_CHECK_EN
        check("oor_l_err", err, 1);
`else
        check("oor_l_err", err, 0);
`endif
        to_pos();

        // randomized traffic, requests held until granted
        for (int c = 0; c < 3000; c++) begin
            to_neg();
            fg = f_gnt;
            lg = l_gnt;
            to_pos();
            reset = (c % 700 == 699);
            if (!f_req || fg) begin
                f_req  = ($urandom_range(0, 3) != 0);
                f_addr = rand_addr();
            end
            if (!l_req || lg) begin
                l_req   = ($urandom_range(0, 2) != 0);
                l_we    = 1'($urandom_range(0, 1));
                l_addr  = rand_addr();
                l_wdata = $urandom();
                if ($urandom_range(0, 3) == 0) l_lock = ~l_lock;
            end
        end
        reset = 0; f_req = 0; l_req = 0;
        to_neg();
        to_pos();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
